ram_arbiter: RTL and testbench

- Shares the single-port system RAM between two requesters: the CPU datapath (port 0) and the program loader / front-panel I/O (port 1).
- Each requester uses a req/ack handshake. The arbiter picks a winner round-robin, drives the RAM address, data and write-enable, waits the RAM read latency, then returns read data and a one-cycle ack.
- Sits between the CPU control/datapath and the RAM, replacing direct CPU ownership of the RAM bus.

---
 rtl/ram_arbiter_pkg.sv | 14 +
 rtl/ram_arbiter_rr_pick2.sv | 30 +++
 rtl/ram_arbiter.sv | 130 +++++++++++++
 tb/tb_ram_arbiter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arbiter_pkg.sv
// rtl/ram_arbiter_pkg.sv - shared state encodings and port indices for ram_arbiter
package ram_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_WAIT   = 2'd2,
    ARB_DONE   = 2'd3
  } arb_state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_LDR = 1'b1;

endpackage

// File: rtl/ram_arbiter_rr_pick2.sv
// rtl/ram_arbiter_rr_pick2.sv - combinational 2-way round-robin picker
// Optional RAM_ARB_LOCK_EN adds a lock input that forces the CPU port to win.
module rr_pick2
  import ram_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
`ifdef RAM_ARB_LOCK_EN
  input  logic       lock,
`endif
  output logic       grant_valid,
  output logic       grant_idx
);

  always_comb begin
    grant_valid = |req;
    grant_idx   = PORT_CPU;
    if (req[PORT_CPU] && req[PORT_LDR]) begin
      grant_idx = ~last;
    end else if (req[PORT_LDR]) begin
      grant_idx = PORT_LDR;
    end
`ifdef RAM_ARB_LOCK_EN
    if (lock && req[PORT_CPU]) begin
      grant_idx = PORT_CPU;
    end
`endif
  end

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - round-robin arbiter sharing a single-port RAM between CPU and loader
// Optional RAM_ARB_LOCK_EN adds cpu_lock for atomic CPU read-modify-write sequences.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 8,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
`ifdef RAM_ARB_LOCK_EN
  input  logic              cpu_lock,
`endif
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic              ldr_ack,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);

  localparam logic [1:0] WAIT_INIT = 2'((READ_LAT > 0) ? READ_LAT - 1 : 0);

  arb_state_t state, state_nxt;
  logic       last_grant;
  logic       cur_port;
  logic       cur_we;
  logic [1:0] wait_cnt;
  logic       grant_valid;
  logic       grant_idx;
  logic       locked;
  logic       capture;

  rr_pick2 u_pick (
    .req         ({ldr_req, cpu_req}),
    .last        (last_grant),
`ifdef RAM_ARB_LOCK_EN
    .lock        (cpu_lock),
`endif
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // Locked grants leave last_grant alone so the loader stays starved while lock holds.
`ifdef RAM_ARB_LOCK_EN
  assign locked = cpu_lock & cpu_req;
`else
  assign locked = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (grant_valid) state_nxt = ARB_ACCESS;
      end
      ARB_ACCESS: begin
        if (cur_we) begin
          state_nxt = ARB_DONE;
        end else if (READ_LAT == 0) begin
          capture   = 1'b1;
          state_nxt = ARB_DONE;
        end else begin
          state_nxt = ARB_WAIT;
        end
      end
      ARB_WAIT: begin
        if (wait_cnt == 2'd0) begin
          capture   = 1'b1;
          state_nxt = ARB_DONE;
        end
      end
      ARB_DONE: state_nxt = ARB_IDLE;
      default:  state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ARB_IDLE;
      last_grant <= PORT_LDR;
      cur_port   <= PORT_CPU;
      cur_we     <= 1'b0;
      wait_cnt   <= 2'd0;
      ram_addr   <= '0;
      ram_we     <= 1'b0;
      ram_wdata  <= '0;
      cpu_rdata  <= '0;
      ldr_rdata  <= '0;
    end else begin
      state  <= state_nxt;
      ram_we <= 1'b0;
      if (state == ARB_IDLE && grant_valid) begin
        cur_port  <= grant_idx;
        cur_we    <= grant_idx ? ldr_we : cpu_we;
        ram_we    <= grant_idx ? ldr_we : cpu_we;
        ram_addr  <= grant_idx ? ldr_addr : cpu_addr;
        ram_wdata <= grant_idx ? ldr_wdata : cpu_wdata;
        if (!locked) last_grant <= grant_idx;
      end
      if (state == ARB_ACCESS) begin
        wait_cnt <= WAIT_INIT;
      end else if (state == ARB_WAIT && wait_cnt != 2'd0) begin
        wait_cnt <= wait_cnt - 2'd1;
      end
      if (capture) begin
        if (cur_port == PORT_CPU) cpu_rdata <= ram_rdata;
        else                      ldr_rdata <= ram_rdata;
      end
    end
  end

  assign cpu_ack = (state == ARB_DONE) && (cur_port == PORT_CPU);
  assign ldr_ack = (state == ARB_DONE) && (cur_port == PORT_LDR);
  assign busy    = (state != ARB_IDLE);

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - self-checking bench for ram_arbiter (RAM_ARB_LOCK_EN optional)
module tb_ram_arbiter;

  localparam int LAT1 = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic       cpu_req, cpu_we, cpu_ack, cpu_lock;
  logic [3:0] cpu_addr;
  logic [7:0] cpu_wdata, cpu_rdata;
  logic       ldr_req, ldr_we, ldr_ack;
  logic [3:0] ldr_addr;
  logic [7:0] ldr_wdata, ldr_rdata;
  logic [3:0] ram_addr;
  logic       ram_we, busy;
  logic [7:0] ram_wdata, ram_rdata;

  logic [7:0] mem [16];
  logic       init_we;
  logic [3:0] init_a;
  logic [7:0] init_d;

  ram_arbiter #(.ADDR_W(4), .DATA_W(8), .READ_LAT(LAT1)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
`ifdef RAM_ARB_LOCK_EN
    .cpu_lock(cpu_lock),
`endif
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_rdata(ldr_rdata), .ldr_ack(ldr_ack),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .busy(busy)
  );

  always @(posedge clk) begin
    if (init_we)     mem[init_a] <= init_d;
    else if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  // Fixed-latency read-only instances: content of address a is {a, ~a}.
  logic       zero1 = 1'b0;
  logic [3:0] fix_addr = 4'hF;
  logic [7:0] zero8 = 8'h00;
  logic       r0_req, r0_ack, r0_busy, r0_we, r0_lack;
  logic [3:0] r0_ram_addr;
  logic [7:0] r0_rdata, r0_ram_rdata, r0_wd, r0_lrd;
  logic       r3_req, r3_ack, r3_busy, r3_we, r3_lack;
  logic [3:0] r3_ram_addr;
  logic [7:0] r3_rdata, r3_ram_rdata, r3_wd, r3_lrd, r3_p1, r3_p2;

  ram_arbiter #(.ADDR_W(4), .DATA_W(8), .READ_LAT(0)) dut_l0 (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(r0_req), .cpu_we(zero1), .cpu_addr(fix_addr), .cpu_wdata(zero8),
    .cpu_rdata(r0_rdata), .cpu_ack(r0_ack),
`ifdef RAM_ARB_LOCK_EN
    .cpu_lock(zero1),
`endif
    .ldr_req(zero1), .ldr_we(zero1), .ldr_addr(fix_addr), .ldr_wdata(zero8),
    .ldr_rdata(r0_lrd), .ldr_ack(r0_lack),
    .ram_addr(r0_ram_addr), .ram_we(r0_we), .ram_wdata(r0_wd), .ram_rdata(r0_ram_rdata),
    .busy(r0_busy)
  );
  assign r0_ram_rdata = {r0_ram_addr, ~r0_ram_addr};

  ram_arbiter #(.ADDR_W(4), .DATA_W(8), .READ_LAT(3)) dut_l3 (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(r3_req), .cpu_we(zero1), .cpu_addr(fix_addr), .cpu_wdata(zero8),
    .cpu_rdata(r3_rdata), .cpu_ack(r3_ack),
`ifdef RAM_ARB_LOCK_EN
    .cpu_lock(zero1),
`endif
    .ldr_req(zero1), .ldr_we(zero1), .ldr_addr(fix_addr), .ldr_wdata(zero8),
    .ldr_rdata(r3_lrd), .ldr_ack(r3_lack),
    .ram_addr(r3_ram_addr), .ram_we(r3_we), .ram_wdata(r3_wd), .ram_rdata(r3_ram_rdata),
    .busy(r3_busy)
  );
  always @(posedge clk) begin
    r3_p1        <= {r3_ram_addr, ~r3_ram_addr};
    r3_p2        <= r3_p1;
    r3_ram_rdata <= r3_p2;
  end

  int passed = 0;
  int total = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: memory image, last round-robin winner, expected rdata registers.
  logic [7:0] ref_mem [16];
  bit         last_m;
  logic [7:0] exp_cpu_rd, exp_ldr_rd;
  int         c_rem, l_rem;
  int         unlock_after = -1;

  function automatic bit lock_on();
`ifdef RAM_ARB_LOCK_EN
    return cpu_lock;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit pick(input bit c, input bit l);
    if (lock_on() && c) return 1'b0;
    if (c && l)         return !last_m;
    return c ? 1'b0 : 1'b1;
  endfunction

  task automatic rand_fields(input bit p);
    if (!p) begin
      cpu_we = 1'($urandom); cpu_addr = 4'($urandom); cpu_wdata = 8'($urandom);
    end else begin
      ldr_we = 1'($urandom); ldr_addr = 4'($urandom); ldr_wdata = 8'($urandom);
    end
  endtask

  // Keeps each port's req high until it has completed nc / nl transactions.
  task automatic serve(input int nc, input int nl, input string tag);
    int cyc = 0, base = 0, seen_we = 0, exp_we = 0, cpu_done = 0;
    bit both = 1'b0, exp_p, got_p, lk, we_x;
    logic [3:0] we_a = '0, a_x;
    logic [7:0] we_d = '0, d_x;
    c_rem = nc; l_rem = nl;
    cpu_req = (nc > 0); ldr_req = (nl > 0);
    while ((c_rem > 0 || l_rem > 0) && cyc < 200) begin
      @(negedge clk); cyc++;
      if (ram_we) begin seen_we++; we_a = ram_addr; we_d = ram_wdata; end
      if (cpu_ack && ldr_ack) both = 1'b1;
      if (cpu_ack || ldr_ack) begin
        exp_p = pick(c_rem > 0, l_rem > 0);
        lk    = lock_on() && (c_rem > 0);
        got_p = ldr_ack;
        chk({tag, "_port"}, 32'(got_p), 32'(exp_p));
        we_x = got_p ? ldr_we : cpu_we;
        a_x  = got_p ? ldr_addr : cpu_addr;
        d_x  = got_p ? ldr_wdata : cpu_wdata;
        chk({tag, "_lat"}, 32'(cyc - base), we_x ? 32'd2 : 32'(2 + LAT1));
        if (we_x) begin
          exp_we++;
          chk({tag, "_waddr"}, 32'(we_a), 32'(a_x));
          chk({tag, "_wdata"}, 32'(we_d), 32'(d_x));
          ref_mem[a_x] = d_x;
        end else if (got_p) exp_ldr_rd = ref_mem[a_x];
        else                exp_cpu_rd = ref_mem[a_x];
        chk({tag, "_cpu_rdata"}, 32'(cpu_rdata), 32'(exp_cpu_rd));
        chk({tag, "_ldr_rdata"}, 32'(ldr_rdata), 32'(exp_ldr_rd));
        if (!lk) last_m = got_p;
        if (!got_p) begin
          c_rem--; cpu_done++;
          if (c_rem == 0) cpu_req = 1'b0; else rand_fields(1'b0);
          if (cpu_done == unlock_after) cpu_lock = 1'b0;
        end else begin
          l_rem--;
          if (l_rem == 0) ldr_req = 1'b0; else rand_fields(1'b1);
        end
        base = cyc + 1;
      end
    end
    chk({tag, "_completed"}, 32'(c_rem + l_rem), 32'd0);
    chk({tag, "_both_acks"}, 32'(both), 32'd0);
    chk({tag, "_we_pulses"}, 32'(seen_we), 32'(exp_we));
    cpu_req = 1'b0; ldr_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int cyc;
    reset_n = 1'b0; init_we = 1'b0; init_a = '0; init_d = '0; cpu_lock = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    ldr_req = 0; ldr_we = 0; ldr_addr = '0; ldr_wdata = '0;
    r0_req = 0; r3_req = 0;
    last_m = 1'b1; exp_cpu_rd = '0; exp_ldr_rd = '0;
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = 8'($urandom);
      @(negedge clk); init_we = 1'b1; init_a = 4'(i); init_d = ref_mem[i];
    end
    @(negedge clk); init_we = 1'b0;

    chk("rst_ram_addr", 32'(ram_addr), 0);
    chk("rst_ram_we", 32'(ram_we), 0);
    chk("rst_ram_wdata", 32'(ram_wdata), 0);
    chk("rst_rdata", 32'({cpu_rdata, ldr_rdata}), 0);
    chk("rst_acks_busy", 32'({cpu_ack, ldr_ack, busy}), 0);
    reset_n = 1'b1;
    @(negedge clk);

    cpu_we = 1; cpu_addr = 4'h3; cpu_wdata = 8'hA5;
    serve(1, 0, "wr_a5");
    chk("idle_hold_addr", 32'(ram_addr), 32'h3);
    chk("idle_hold_wdata", 32'(ram_wdata), 32'hA5);

    cpu_we = 1; cpu_addr = 4'h7; cpu_wdata = 8'h5A;
    serve(1, 0, "wr_5a");
    ldr_we = 0; ldr_addr = 4'h7;
    serve(0, 1, "ldr_rd7");
    chk("ldr_rd7_value", 32'(ldr_rdata), 32'h5A);

    rand_fields(1'b0); rand_fields(1'b1);
    serve(3, 3, "contend");

    cpu_we = 1; cpu_addr = 4'h9; cpu_wdata = 8'h3C; cpu_req = 1;
    @(negedge clk);
    chk("rst_mid_we_before", 32'(ram_we), 1);
    reset_n = 1'b0; #1;
    chk("rst_mid_we", 32'(ram_we), 0);
    chk("rst_mid_busy", 32'(busy), 0);
    chk("rst_mid_ack", 32'({cpu_ack, ldr_ack}), 0);
    last_m = 1'b1; exp_cpu_rd = '0; exp_ldr_rd = '0;
    @(negedge clk);
    chk("rst_mid_no_ack", 32'({cpu_ack, ldr_ack}), 0);
    reset_n = 1'b1;
    serve(1, 0, "rerequest");

    r0_req = 1; cyc = 0;
    while (!r0_ack && cyc < 20) begin @(negedge clk); cyc++; end
    chk("lat0_cycles", 32'(cyc), 32'd2);
    chk("lat0_data", 32'(r0_rdata), 32'hF0);
    r0_req = 0;
    r3_req = 1; cyc = 0;
    while (!r3_ack && cyc < 20) begin @(negedge clk); cyc++; end
    chk("lat3_cycles", 32'(cyc), 32'd5);
    chk("lat3_data", 32'(r3_rdata), 32'hF0);
    r3_req = 0;
    @(negedge clk);

`ifdef RAM_ARB_LOCK_EN
    cpu_we = 0; cpu_addr = 4'h1;
    serve(1, 0, "pre_lock");
    rand_fields(1'b0); rand_fields(1'b1);
    cpu_lock = 1'b1; unlock_after = 3;
    serve(4, 1, "lock");
    unlock_after = -1; cpu_lock = 1'b0;
`endif

    for (int k = 0; k < 15; k++) begin
      int nc, nl;
      nc = int'($urandom_range(0, 2));
      nl = int'($urandom_range(0, 2));
      if (nc == 0 && nl == 0) nc = 1;
      rand_fields(1'b0); rand_fields(1'b1);
      serve(nc, nl, "rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
